// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR4 DQ bus scheduler: directions,
// burst length, default latencies and the scheduler config record.
package ddr_pkg;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } dir_e;

  localparam int BURST_TCK = 4;

  localparam logic [5:0] DEF_CL  = 6'd11;
  localparam logic [5:0] DEF_CWL = 6'd9;
  localparam logic [1:0] DEF_PRE = 2'd1;

  typedef struct packed {
    logic [5:0] cl;
    logic [5:0] cwl;
    logic [1:0] pre;
  } sched_cfg_t;

  // A latency needs two cycles between the grant and the preamble start.
  function automatic logic lat_ok(input logic [5:0] lat, input logic [1:0] pre,
                                  input int lat_max);
    int l;
    int p;
    l = int'(lat);
    p = int'(pre);
    return ((l - p) >= 2) && (l <= lat_max);
  endfunction

  function automatic logic cfg_legal(input sched_cfg_t c, input int lat_max);
    return ((c.pre == 2'd1) || (c.pre == 2'd2)) &&
           lat_ok(c.cl, c.pre, lat_max) && lat_ok(c.cwl, c.pre, lat_max);
  endfunction

endpackage

// File: rtl/ddr_launch_pipe.sv
// Launch delay line: a load at index i makes start pulse exactly i+1 cycles later.
// Several launches may be in flight at once, one bit each.
module ddr_launch_pipe #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             CK_t,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  output logic             start,
  output logic             any
);

  logic [DEPTH-1:0] pipe_reg;
  logic [DEPTH-1:0] pipe_next;
  logic [DEPTH-1:0] load_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_load
      assign load_vec[gi] = load && (idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    pipe_next = {1'b0, pipe_reg[DEPTH-1:1]} | load_vec;
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  assign start = pipe_reg[0];
  assign any   = |pipe_reg;

endmodule

// File: rtl/ddr_dq_bus_sched.sv
// Read/write column arbiter for the shared DQ bus: tracks bus occupancy,
// enforces seamless/turnaround spacing and launches the data-pin start pulses.
module ddr_dq_bus_sched
  import ddr_pkg::*;
#(
  parameter int LAT_MAX   = 32,
  parameter int WR_STARVE = 16
) (
  input  logic       CK_t,
  input  logic       reset,
  input  logic       cfg_load,
  input  logic [5:0] cfg_cl,
  input  logic [5:0] cfg_cwl,
  input  logic [1:0] cfg_pre,
  input  logic       rd_req,
  output logic       rd_ack,
  input  logic       wr_req,
  output logic       wr_ack,
  output logic       rd_start_dd,
  output logic       wr_start_dd,
  output logic       busy,
  output logic       cfg_err
);

  localparam int IDX_W  = $clog2(LAT_MAX);
  localparam int WAIT_W = $clog2(WR_STARVE + 1);
  localparam logic [WAIT_W-1:0] STARVE_LIM = WAIT_W'(WR_STARVE);
  localparam logic [6:0] BURST_TAIL = 7'(BURST_TCK - 1);

  sched_cfg_t        cfg_reg, cfg_next, cfg_in;
  dir_e              last_dir_reg, last_dir_next;
  logic [6:0]        rem_reg, rem_next;
  logic [WAIT_W-1:0] wr_wait_reg, wr_wait_next;
  logic              cfg_err_reg, cfg_err_next;

  logic [6:0] rd_lat, wr_lat, pre_w, rd_launch, wr_launch;
  logic       rd_elig, wr_elig, wr_first, rd_grant, wr_grant;
  logic       rd_any, wr_any;

  always_comb begin
    rd_lat    = {1'b0, cfg_reg.cl};
    wr_lat    = {1'b0, cfg_reg.cwl};
    pre_w     = {5'b0, cfg_reg.pre};
    rd_launch = rd_lat - pre_w - 7'd1;
    wr_launch = wr_lat - pre_w - 7'd1;

    // Turnaround needs one idle DQ cycle ahead of the new direction's preamble.
    if (last_dir_reg == RD) begin
      rd_elig = rd_lat >= rem_reg;
      wr_elig = (wr_lat - pre_w) >= (rem_reg + 7'd1);
    end else begin
      wr_elig = wr_lat >= rem_reg;
      rd_elig = (rd_lat - pre_w) >= (rem_reg + 7'd1);
    end

    // A starved write blocks reads so the bus can drain to a write window.
    wr_first = wr_wait_reg >= STARVE_LIM;
    rd_grant = !reset && rd_req && rd_elig && !(wr_first && wr_req);
    wr_grant = !reset && wr_req && wr_elig && !rd_grant;
  end

  always_comb begin
    rem_next      = rem_reg;
    last_dir_next = last_dir_reg;
    wr_wait_next  = wr_wait_reg;
    cfg_next      = cfg_reg;
    cfg_err_next  = cfg_err_reg;
    cfg_in        = '{cl: cfg_cl, cwl: cfg_cwl, pre: cfg_pre};

    if (rd_grant) begin
      rem_next      = rd_lat + BURST_TAIL;
      last_dir_next = RD;
    end else if (wr_grant) begin
      rem_next      = wr_lat + BURST_TAIL;
      last_dir_next = WR;
    end else if (rem_reg != 7'd0) begin
      rem_next = rem_reg - 7'd1;
    end

    if (wr_grant) begin
      wr_wait_next = '0;
    end else if (wr_req && (wr_wait_reg != STARVE_LIM)) begin
      wr_wait_next = wr_wait_reg + 1'b1;
    end

    if (cfg_load) begin
      if (busy || !cfg_legal(cfg_in, LAT_MAX)) begin
        cfg_err_next = 1'b1;
      end else begin
        cfg_next = cfg_in;
      end
    end
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      cfg_reg      <= '{cl: DEF_CL, cwl: DEF_CWL, pre: DEF_PRE};
      last_dir_reg <= RD;
      rem_reg      <= '0;
      wr_wait_reg  <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      cfg_reg      <= cfg_next;
      last_dir_reg <= last_dir_next;
      rem_reg      <= rem_next;
      wr_wait_reg  <= wr_wait_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

  ddr_launch_pipe #(.DEPTH(LAT_MAX)) u_rd_pipe (
    .CK_t  (CK_t),
    .reset (reset),
    .load  (rd_grant),
    .idx   (rd_launch[IDX_W-1:0]),
    .start (rd_start_dd),
    .any   (rd_any)
  );

  ddr_launch_pipe #(.DEPTH(LAT_MAX)) u_wr_pipe (
    .CK_t  (CK_t),
    .reset (reset),
    .load  (wr_grant),
    .idx   (wr_launch[IDX_W-1:0]),
    .start (wr_start_dd),
    .any   (wr_any)
  );

  assign busy    = rd_any || wr_any || (rem_reg != 7'd0);
  assign rd_ack  = rd_grant;
  assign wr_ack  = wr_grant;
  assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_ddr_dq_bus_sched.sv
// Directed bench for ddr_dq_bus_sched: table-driven grant-pair and config
// vectors plus hand-written multi-cycle sequences.
module tb_ddr_dq_bus_sched;

  logic       CK_t = 1'b0;
  logic       reset, cfg_load, rd_req, wr_req;
  logic [5:0] cfg_cl, cfg_cwl;
  logic [1:0] cfg_pre;
  logic       rd_ack, wr_ack, rd_start_dd, wr_start_dd, busy, cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CK_t = ~CK_t;

  ddr_dq_bus_sched dut (
    .CK_t        (CK_t),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_cl      (cfg_cl),
    .cfg_cwl     (cfg_cwl),
    .cfg_pre     (cfg_pre),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .wr_req      (wr_req),
    .wr_ack      (wr_ack),
    .rd_start_dd (rd_start_dd),
    .wr_start_dd (wr_start_dd),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  // Two-grant scenario: first request d1 at t=0, then d2 held from t=1.
  // Directions: 0 = read, 1 = write. Times relative to the first ack.
  typedef struct {
    int cl; int cwl; int pre;
    int d1; int d2;
    int gap; int st1; int st2;
  } pair_t;

  typedef struct {
    int cl; int cwl; int pre; int err;
  } cfgv_t;

  pair_t pairs[8];
  cfgv_t cfgs[9];

  int ack_t[2][8];
  int st_t[2][8];
  int n_ack[2];
  int n_st[2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CK_t);
    #1;
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    cfg_load = 1'b0;
    tick();
    @(negedge CK_t);
    chk("reset_outputs", int'({rd_ack, wr_ack, rd_start_dd, wr_start_dd, busy, cfg_err}), 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic load_cfg(input int cl, input int cwl, input int pre);
    cfg_cl   = 6'(cl);
    cfg_cwl  = 6'(cwl);
    cfg_pre  = 2'(pre);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Issue one read on an idle bus and check its start offset from the ack.
  task automatic measure_read(input string name, input int exp_off);
    int st;
    st     = -1;
    rd_req = 1'b1;
    @(negedge CK_t);
    chk({name, "_ack"}, int'(rd_ack), 1);
    tick();
    rd_req = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge CK_t);
      if (rd_start_dd && st < 0) st = t;
      tick();
    end
    chk({name, "_start"}, st, exp_off);
    @(negedge CK_t);
    chk({name, "_idle"}, int'(busy), 0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got2, i2, d1, d2, st, nst;

    pairs[0] = '{11, 9, 1, 0, 0, 4, 10, 14};
    pairs[1] = '{11, 9, 1, 1, 0, 4, 8, 14};
    pairs[2] = '{11, 9, 1, 0, 1, 8, 10, 16};
    pairs[3] = '{11, 9, 1, 1, 1, 4, 8, 12};
    pairs[4] = '{20, 15, 2, 0, 1, 12, 18, 25};
    pairs[5] = '{20, 15, 2, 1, 0, 2, 13, 20};
    pairs[6] = '{20, 15, 2, 0, 0, 4, 18, 22};
    pairs[7] = '{11, 9, 2, 1, 0, 5, 7, 14};

    cfgs[0] = '{2, 9, 1, 1};
    cfgs[1] = '{11, 9, 0, 1};
    cfgs[2] = '{11, 9, 3, 1};
    cfgs[3] = '{33, 9, 1, 1};
    cfgs[4] = '{11, 33, 1, 1};
    cfgs[5] = '{11, 2, 1, 1};
    cfgs[6] = '{3, 3, 1, 0};
    cfgs[7] = '{32, 32, 2, 0};
    cfgs[8] = '{4, 9, 2, 0};

    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; cfg_load = 1'b0;
    cfg_cl = 6'd11; cfg_cwl = 6'd9; cfg_pre = 2'd1;

    // Single read at t=5 with default config.
    do_reset();
    for (int t = 0; t < 25; t++) begin
      rd_req = (t == 5);
      @(negedge CK_t);
      chk($sformatf("single_rd_ack@%0d", t), int'(rd_ack), int'(t == 5));
      chk($sformatf("single_rd_start@%0d", t), int'(rd_start_dd), int'(t == 15));
      chk($sformatf("single_busy@%0d", t), int'(busy), int'(t >= 6 && t <= 19));
      chk($sformatf("single_wr_quiet@%0d", t), int'(wr_ack | wr_start_dd), 0);
      tick();
    end
    rd_req = 1'b0;
    $display("single read sequence done");

    // Continuous reads: seamless at tCCD=4.
    do_reset();
    for (int t = 0; t < 30; t++) begin
      rd_req = (t < 20);
      @(negedge CK_t);
      chk($sformatf("stream_rd_ack@%0d", t), int'(rd_ack), int'(t < 20 && t % 4 == 0));
      chk($sformatf("stream_rd_start@%0d", t), int'(rd_start_dd),
          int'(t >= 10 && t <= 26 && (t - 10) % 4 == 0));
      chk($sformatf("stream_busy@%0d", t), int'(busy), int'(t >= 1));
      tick();
    end
    rd_req = 1'b0;
    $display("read stream sequence done");

    // Two-grant spacing table.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      load_cfg(pairs[r].cl, pairs[r].cwl, pairs[r].pre);
      @(negedge CK_t);
      chk($sformatf("pair%0d_cfg_err", r), int'(cfg_err), 0);
      tick();
      d1 = pairs[r].d1;
      d2 = pairs[r].d2;
      n_ack[0] = 0; n_ack[1] = 0; n_st[0] = 0; n_st[1] = 0;
      got2 = 0;
      for (int t = 0; t < 40; t++) begin
        rd_req = (d1 == 0 && t == 0) || (d2 == 0 && t >= 1 && got2 == 0);
        wr_req = (d1 == 1 && t == 0) || (d2 == 1 && t >= 1 && got2 == 0);
        @(negedge CK_t);
        if (rd_ack) begin
          if (n_ack[0] < 8) ack_t[0][n_ack[0]] = t;
          n_ack[0]++;
        end
        if (wr_ack) begin
          if (n_ack[1] < 8) ack_t[1][n_ack[1]] = t;
          n_ack[1]++;
        end
        if (t >= 1 && ((rd_ack && d2 == 0) || (wr_ack && d2 == 1))) got2 = 1;
        if (rd_start_dd) begin
          if (n_st[0] < 8) st_t[0][n_st[0]] = t;
          n_st[0]++;
        end
        if (wr_start_dd) begin
          if (n_st[1] < 8) st_t[1][n_st[1]] = t;
          n_st[1]++;
        end
        tick();
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      i2 = (d1 == d2) ? 1 : 0;
      chk($sformatf("pair%0d_ack1", r), (n_ack[d1] > 0) ? ack_t[d1][0] : -1, 0);
      chk($sformatf("pair%0d_ack2", r), (n_ack[d2] > i2) ? ack_t[d2][i2] : -1, pairs[r].gap);
      chk($sformatf("pair%0d_start1", r), (n_st[d1] > 0) ? st_t[d1][0] : -1, pairs[r].st1);
      chk($sformatf("pair%0d_start2", r), (n_st[d2] > i2) ? st_t[d2][i2] : -1, pairs[r].st2);
      chk($sformatf("pair%0d_n_ack", r), n_ack[0] + n_ack[1], 2);
      chk($sformatf("pair%0d_n_start", r), n_st[0] + n_st[1], 2);
      $display("pair %0d: dir %0d->%0d cl=%0d cwl=%0d p=%0d checked", r, d1, d2,
               pairs[r].cl, pairs[r].cwl, pairs[r].pre);
    end

    // Write starvation: both requests held continuously.
    do_reset();
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int t = 0; t < 45; t++) begin
      @(negedge CK_t);
      chk($sformatf("starve_rd_ack@%0d", t), int'(rd_ack),
          int'(t inside {0, 4, 8, 12, 24, 28, 32, 36}));
      chk($sformatf("starve_wr_ack@%0d", t), int'(wr_ack), int'(t inside {20, 44}));
      tick();
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    $display("starvation sequence done");

    // Config vectors; rejected loads must leave the defaults in force.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      load_cfg(cfgs[i].cl, cfgs[i].cwl, cfgs[i].pre);
      @(negedge CK_t);
      chk($sformatf("cfg%0d_err", i), int'(cfg_err), cfgs[i].err);
      tick();
      measure_read($sformatf("cfg%0d", i),
                   (cfgs[i].err != 0) ? 10 : cfgs[i].cl - cfgs[i].pre);
      $display("cfg %0d: cl=%0d cwl=%0d p=%0d checked", i, cfgs[i].cl, cfgs[i].cwl, cfgs[i].pre);
    end

    // cfg_load while busy is ignored and flagged.
    do_reset();
    rd_req = 1'b1;
    @(negedge CK_t);
    tick();
    rd_req = 1'b0;
    cfg_cl = 6'd20; cfg_cwl = 6'd9; cfg_pre = 2'd1;
    cfg_load = 1'b1;
    @(negedge CK_t);
    chk("busy_load_busy", int'(busy), 1);
    tick();
    cfg_load = 1'b0;
    @(negedge CK_t);
    chk("busy_load_err", int'(cfg_err), 1);
    tick();
    for (int t = 0; t < 40; t++) tick();
    measure_read("busy_load", 10);
    @(negedge CK_t);
    chk("busy_load_err_sticky", int'(cfg_err), 1);
    tick();
    $display("busy cfg_load sequence done");

    // cfg_load in the same cycle as a grant: grant keeps the old latency.
    do_reset();
    cfg_cl = 6'd20; cfg_cwl = 6'd9; cfg_pre = 2'd1;
    cfg_load = 1'b1;
    rd_req   = 1'b1;
    @(negedge CK_t);
    chk("same_cycle_ack", int'(rd_ack), 1);
    tick();
    cfg_load = 1'b0;
    rd_req   = 1'b0;
    st = -1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge CK_t);
      if (rd_start_dd && st < 0) st = t;
      tick();
    end
    chk("same_cycle_start", st, 10);
    chk("same_cycle_err", int'(cfg_err), 0);
    measure_read("same_cycle_new", 19);
    $display("same-cycle cfg_load sequence done");

    // Reset between ack and start pulse drops the launch.
    do_reset();
    rd_req = 1'b1;
    @(negedge CK_t);
    chk("midrst_ack0", int'(rd_ack), 1);
    tick();
    rd_req = 1'b0;
    for (int t = 1; t < 5; t++) tick();
    reset  = 1'b1;
    rd_req = 1'b1;
    @(negedge CK_t);
    chk("midrst_ack_in_reset", int'(rd_ack), 0);
    tick();
    reset  = 1'b0;
    rd_req = 1'b0;
    @(negedge CK_t);
    chk("midrst_outputs", int'({rd_ack, wr_ack, rd_start_dd, wr_start_dd, busy, cfg_err}), 0);
    tick();
    rd_req = 1'b1;
    @(negedge CK_t);
    chk("midrst_regrant", int'(rd_ack), 1);
    tick();
    rd_req = 1'b0;
    st  = -1;
    nst = 0;
    for (int t = 8; t <= 30; t++) begin
      @(negedge CK_t);
      if (rd_start_dd) begin
        nst++;
        if (st < 0) st = t;
      end
      tick();
    end
    chk("midrst_n_start", nst, 1);
    chk("midrst_start_cycle", st, 17);
    $display("mid-operation reset sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
